// File: rtl/tqvp_sprite_motion_pkg.sv
// Shared constants for the sprite motion sequencer: CPU register map, FSM
// encoding, engine write addresses and the collision box helper.
package tqvp_sprite_motion_pkg;

    localparam logic [7:0] MAX_X    = 8'd244;
    localparam logic [7:0] MAX_Y    = 8'd180;
    localparam logic [7:0] SPR_SIZE = 8'd12;

    localparam logic [5:0] S0_ADDR = 6'h04;
    localparam logic [5:0] S1_ADDR = 6'h1A;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_DIV    = 4'h1;
    localparam logic [3:0] REG_S0_POS = 4'h2;
    localparam logic [3:0] REG_S0_VEL = 4'h4;
    localparam logic [3:0] REG_S1_POS = 4'h6;
    localparam logic [3:0] REG_S1_VEL = 4'h8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_WR0  = 2'd2;
    localparam logic [1:0] ST_WR1  = 2'd3;

    function automatic logic boxes_overlap(input logic [7:0] x0, input logic [7:0] y0,
                                           input logic [7:0] x1, input logic [7:0] y1);
        logic [7:0] dx;
        logic [7:0] dy;
        dx = (x0 > x1) ? (x0 - x1) : (x1 - x0);
        dy = (y0 > y1) ? (y0 - y1) : (y1 - y0);
        return (dx < SPR_SIZE) && (dy < SPR_SIZE);
    endfunction

endpackage

// File: rtl/tqvp_sprite_motion_if.sv
// Valid/ready write port into the sprite engine's shadow registers.
interface tqvp_sprite_motion_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/tqvp_sprite_motion_sprite_axis_step.sv
// One axis of sprite motion: advance by signed velocity, clamp and bounce at 0 / max.
module sprite_axis_step (
    input  logic [7:0] pos,
    input  logic [3:0] vel,
    input  logic [7:0] max,
    output logic [7:0] new_pos,
    output logic [3:0] new_vel
);
    logic signed [9:0] n;
    logic [3:0]        neg_vel;

    always_comb begin
        n       = $signed({2'b00, pos}) + $signed({{6{vel[3]}}, vel});
        // -(-8) does not fit in 4 bits, so it saturates to +7
        neg_vel = (vel == 4'b1000) ? 4'b0111 : (~vel + 4'd1);
        new_pos = pos;
        new_vel = vel;
        if (n < 0) begin
            new_pos = '0;
            new_vel = neg_vel;
        end else if (n > $signed({2'b00, max})) begin
            new_pos = max;
            new_vel = neg_vel;
        end else begin
            new_pos = n[7:0];
        end
    end
endmodule

// File: rtl/tqvp_sprite_motion.sv
// Sprite motion sequencer: per-frame position update and two engine writes.
// Optional collision flag/interrupt enabled by SPRITE_MOTION_COLLIDE_EN.
module tqvp_sprite_motion
    import tqvp_sprite_motion_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  address,
    input  logic [15:0]                 data_in,
    input  logic [1:0]                  data_write_n,
    output logic [15:0]                 data_out,
    input  logic                        frame_tick,
    tqvp_sprite_motion_if.master        wr,
    output logic                        user_interrupt
);
    logic [1:0]  state;
    logic        enable;
    logic [7:0]  div, div_cnt;
    logic [15:0] s0_pos, s1_pos, s1_buf;
    logic [7:0]  s0_vel, s1_vel;
    logic [7:0]  nx0, ny0, nx1, ny1;
    logic [3:0]  ndx0, ndy0, ndx1, ndy1;
    logic [15:0] ctrl_rd;
    logic        wr_en;

    assign wr_en = (data_write_n != 2'b11);

    sprite_axis_step u_x0 (.pos(s0_pos[7:0]),  .vel(s0_vel[3:0]), .max(MAX_X), .new_pos(nx0), .new_vel(ndx0));
    sprite_axis_step u_y0 (.pos(s0_pos[15:8]), .vel(s0_vel[7:4]), .max(MAX_Y), .new_pos(ny0), .new_vel(ndy0));
    sprite_axis_step u_x1 (.pos(s1_pos[7:0]),  .vel(s1_vel[3:0]), .max(MAX_X), .new_pos(nx1), .new_vel(ndx1));
    sprite_axis_step u_y1 (.pos(s1_pos[15:8]), .vel(s1_vel[7:4]), .max(MAX_Y), .new_pos(ny1), .new_vel(ndy1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            enable      <= 1'b0;
            div         <= '0;
            div_cnt     <= '0;
            s0_pos      <= '0;
            s1_pos      <= '0;
            s0_vel      <= '0;
            s1_vel      <= '0;
            s1_buf      <= '0;
            wr.wr_valid <= 1'b0;
            wr.wr_addr  <= '0;
            wr.wr_data  <= '0;
        end else begin
            if (wr_en && address == REG_CTRL) enable <= data_in[0];
            if (wr_en && address == REG_DIV)  div    <= data_in[7:0];

            // A CPU write in the CALC cycle takes precedence over the motion update
            if (wr_en && address == REG_S0_POS)  s0_pos <= data_in;
            else if (state == ST_CALC)           s0_pos <= {ny0, nx0};
            if (wr_en && address == REG_S0_VEL)  s0_vel <= data_in[7:0];
            else if (state == ST_CALC)           s0_vel <= {ndy0, ndx0};
            if (wr_en && address == REG_S1_POS)  s1_pos <= data_in;
            else if (state == ST_CALC)           s1_pos <= {ny1, nx1};
            if (wr_en && address == REG_S1_VEL)  s1_vel <= data_in[7:0];
            else if (state == ST_CALC)           s1_vel <= {ndy1, ndx1};

            case (state)
                ST_IDLE: begin
                    if (frame_tick && enable) begin
                        if (div_cnt == '0) begin
                            state   <= ST_CALC;
                            div_cnt <= div;
                        end else begin
                            div_cnt <= div_cnt - 8'd1;
                        end
                    end
                end
                ST_CALC: begin
                    state       <= ST_WR0;
                    wr.wr_valid <= 1'b1;
                    wr.wr_addr  <= S0_ADDR;
                    wr.wr_data  <= {ny0, nx0};
                    s1_buf      <= {ny1, nx1};
                end
                ST_WR0: begin
                    if (wr.wr_ready) begin
                        state      <= ST_WR1;
                        wr.wr_addr <= S1_ADDR;
                        wr.wr_data <= s1_buf;
                    end
                end
                default: begin
                    if (wr.wr_ready) begin
                        state       <= ST_IDLE;
                        wr.wr_valid <= 1'b0;
                    end
                end
            endcase

            if (wr_en && address == REG_DIV) div_cnt <= data_in[7:0];
        end
    end

`ifdef SPRITE_MOTION_COLLIDE_EN
    logic irq_en, coll_flag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_en    <= 1'b0;
            coll_flag <= 1'b0;
        end else begin
            if (wr_en && address == REG_CTRL) begin
                irq_en <= data_in[1];
                if (data_in[2]) coll_flag <= 1'b0;
            end
            if (state == ST_CALC && boxes_overlap(nx0, ny0, nx1, ny1)) coll_flag <= 1'b1;
        end
    end

    assign user_interrupt = coll_flag && irq_en;
    assign ctrl_rd        = {13'b0, coll_flag, irq_en, enable};
`else
    assign user_interrupt = 1'b0;
    assign ctrl_rd        = {15'b0, enable};
`endif

    always_comb begin
        data_out = '0;
        case (address)
            REG_CTRL:   data_out = ctrl_rd;
            REG_DIV:    data_out = {8'b0, div};
            REG_S0_POS: data_out = s0_pos;
            REG_S0_VEL: data_out = {8'b0, s0_vel};
            REG_S1_POS: data_out = s1_pos;
            REG_S1_VEL: data_out = {8'b0, s1_vel};
            default:    data_out = '0;
        endcase
    end
endmodule

// File: tb/tb_tqvp_sprite_motion.sv
// Bench for tqvp_sprite_motion: vector table plus write-port scoreboard.
module tb_tqvp_sprite_motion;
    import tqvp_sprite_motion_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  address;
    logic [15:0] data_in;
    logic [1:0]  data_write_n;
    logic [15:0] data_out;
    logic        frame_tick;
    logic        user_interrupt;

    tqvp_sprite_motion_if wr_if();

    tqvp_sprite_motion dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_out(data_out), .frame_tick(frame_tick),
        .wr(wr_if), .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] p0, p1;
        logic [7:0]  v0, v1;
        logic [15:0] w0, w1;
        logic [7:0]  nv0, nv1;
    } vec_t;

    vec_t        vecs[4];
    logic [21:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accepted beats are observed on the negedge ahead of the accepting posedge
    always @(negedge clk) begin
        if (rst_n && wr_if.wr_valid && wr_if.wr_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got %h expected none", {wr_if.wr_addr, wr_if.wr_data});
            end else begin
                check("wr_beat", {wr_if.wr_addr, wr_if.wr_data}, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [15:0] d);
        address = a;
        data_in = d;
        data_write_n = 2'b01;
        step(1);
        data_write_n = 2'b11;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [15:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic push_pair(input logic [15:0] w0, input logic [15:0] w1);
        exp_q.push_back({S0_ADDR, w0});
        exp_q.push_back({S1_ADDR, w1});
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            step(1);
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        step(2);
    endtask

    logic [15:0] rd;
    int          acc0;

    initial begin
        vecs[0] = '{16'h140A, 16'h3232, 8'hE3, 8'h11, 16'h120D, 16'h3333, 8'hE3, 8'h11};
        vecs[1] = '{16'h01F3, 16'hB302, 8'hC3, 8'h78, 16'h00F4, 16'hB400, 8'h4D, 8'h97};
        vecs[2] = '{16'hB4F4, 16'h0000, 8'h00, 8'h1F, 16'hB4F4, 16'h0100, 8'h00, 8'h11};
        vecs[3] = '{16'h6464, 16'h00F1, 8'h78, 8'h83, 16'h6B5C, 16'h00F4, 8'h78, 8'h73};

        rst_n = 1'b0;
        address = '0;
        data_in = '0;
        data_write_n = 2'b11;
        frame_tick = 1'b0;
        wr_if.wr_ready = 1'b1;
        step(3);
        check("rst_wr_valid", wr_if.wr_valid, 0);
        check("rst_wr_addr", wr_if.wr_addr, 0);
        check("rst_wr_data", wr_if.wr_data, 0);
        check("rst_irq", user_interrupt, 0);
        cpu_read(REG_S0_POS, rd);
        check("rst_s0_pos", rd, 0);
        rst_n = 1'b1;
        step(1);

        cpu_write(REG_DIV, 16'h0000);
        cpu_write(REG_CTRL, 16'h0001);

        for (int i = 0; i < 4; i++) begin
            cpu_write(REG_S0_POS, vecs[i].p0);
            cpu_write(REG_S0_VEL, {8'h00, vecs[i].v0});
            cpu_write(REG_S1_POS, vecs[i].p1);
            cpu_write(REG_S1_VEL, {8'h00, vecs[i].v1});
            push_pair(vecs[i].w0, vecs[i].w1);
            pulse_tick();
            check("lat_t1_valid", wr_if.wr_valid, 0);
            step(1);
            check("lat_t2_valid", wr_if.wr_valid, 1);
            check("lat_t2_addr", wr_if.wr_addr, S0_ADDR);
            step(1);
            check("lat_t3_addr", wr_if.wr_addr, S1_ADDR);
            step(1);
            check("lat_t4_valid", wr_if.wr_valid, 0);
            drain();
            cpu_read(REG_S0_POS, rd); check("vec_s0_pos", rd, vecs[i].w0);
            cpu_read(REG_S1_POS, rd); check("vec_s1_pos", rd, vecs[i].w1);
            cpu_read(REG_S0_VEL, rd); check("vec_s0_vel", rd, {8'h00, vecs[i].nv0});
            cpu_read(REG_S1_VEL, rd); check("vec_s1_vel", rd, {8'h00, vecs[i].nv1});
        end

        // Divider: DIV=2 updates on the 3rd and 6th tick only
        cpu_write(REG_S0_POS, 16'h1010);
        cpu_write(REG_S0_VEL, 16'h0011);
        cpu_write(REG_S1_POS, 16'h2020);
        cpu_write(REG_S1_VEL, 16'h0000);
        cpu_write(REG_DIV, 16'h0002);
        acc0 = n_acc;
        for (int t = 1; t <= 6; t++) begin
            if (t == 3) push_pair(16'h1111, 16'h2020);
            if (t == 6) push_pair(16'h1212, 16'h2020);
            pulse_tick();
            step(6);
            check("div_pairs", n_acc - acc0, (t >= 6) ? 4 : (t >= 3) ? 2 : 0);
        end
        drain();
        cpu_write(REG_DIV, 16'h0000);

        // Stall in WR0 with ticks arriving during the stall
        cpu_write(REG_S0_POS, 16'h2040);
        cpu_write(REG_S0_VEL, 16'h0000);
        wr_if.wr_ready = 1'b0;
        acc0 = n_acc;
        push_pair(16'h2040, 16'h2020);
        pulse_tick();
        step(1);
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", wr_if.wr_valid, 1);
            check("stall_addr", wr_if.wr_addr, S0_ADDR);
            check("stall_data", wr_if.wr_data, 16'h2040);
            frame_tick = (c == 1 || c == 3);
            step(1);
        end
        frame_tick = 1'b0;
        wr_if.wr_ready = 1'b1;
        drain();
        step(8);
        check("stall_no_extra", n_acc - acc0, 2);
        check("stall_idle_valid", wr_if.wr_valid, 0);

        // CPU write in the CALC cycle wins over the motion update
        cpu_write(REG_S0_POS, 16'h3030);
        cpu_write(REG_S0_VEL, 16'h0011);
        push_pair(16'h3131, 16'h2020);
        pulse_tick();
        cpu_write(REG_S0_POS, 16'h0505);
        drain();
        cpu_read(REG_S0_POS, rd);
        check("calc_override", rd, 16'h0505);

        // Reset during WR0
        wr_if.wr_ready = 1'b0;
        pulse_tick();
        step(1);
        check("pre_rst_valid", wr_if.wr_valid, 1);
        rst_n = 1'b0;
        step(1);
        check("midrst_valid", wr_if.wr_valid, 0);
        check("midrst_state", dut.state, ST_IDLE);
        rst_n = 1'b1;
        wr_if.wr_ready = 1'b1;
        step(1);

        // Overlapping sprites
        cpu_write(REG_S0_POS, 16'h6464);
        cpu_write(REG_S1_POS, 16'h5F69);
        cpu_write(REG_CTRL, 16'h0003);
        push_pair(16'h6464, 16'h5F69);
        pulse_tick();
        drain();
`ifdef SPRITE_MOTION_COLLIDE_EN
        check("coll_irq", user_interrupt, 1);
        cpu_read(REG_CTRL, rd); check("coll_ctrl", rd, 16'h0007);
        cpu_write(REG_CTRL, 16'h0007);
        check("coll_clear", user_interrupt, 0);
        cpu_read(REG_CTRL, rd); check("coll_ctrl_clr", rd, 16'h0003);
        push_pair(16'h6464, 16'h5F69);
        pulse_tick();
        cpu_write(REG_CTRL, 16'h0007);
        drain();
        check("coll_set_wins", user_interrupt, 1);
`else
        check("coll_irq_off", user_interrupt, 0);
        cpu_read(REG_CTRL, rd); check("coll_ctrl_off", rd, 16'h0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
